// File: rtl/sram_cfg_pkg.sv
// Mode constants and row/slot helper functions shared by the aspect-ratio
// controller. Helpers work on a wide row_t so any ROW_W up to MAX_ROW_W can
// use them. Callers size-cast the result down to their own row width.
package sram_cfg_pkg;

  localparam int MAX_ROW_W = 256;
  typedef logic [MAX_ROW_W-1:0] row_t;

  // Mode encodings for a 32-bit row. Mode k gives words of 32>>k bits.
  typedef enum logic [2:0] {
    MODE_X32 = 3'd0,
    MODE_X16 = 3'd1,
    MODE_X8  = 3'd2,
    MODE_X4  = 3'd3,
    MODE_X2  = 3'd4,
    MODE_X1  = 3'd5
  } mode32_e;

  // Mask of w ones, right-aligned.
  function automatic row_t lane_ones(input int w);
    row_t ones;
    ones = '1;
    return ones >> (MAX_ROW_W - w);
  endfunction

  // Bit-line write mask for a narrow word sitting in the given slot.
  function automatic row_t wmask_f(input int mode, input int slot, input int row_w = 32);
    int w;
    w = row_w >> mode;
    return lane_ones(w) << (slot * w);
  endfunction

  // Narrow word in the given slot, right-aligned and zero-extended.
  function automatic row_t extract_f(input int mode, input int slot, input row_t row,
                                     input int row_w = 32);
    int w;
    w = row_w >> mode;
    return (row >> (slot * w)) & lane_ones(w);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response buffer: DEPTH x WIDTH synchronous FIFO with an occupancy count.
// Ports: clk, rst (sync, active-high); push/push_data write side;
// pop/pop_data read side (pop_data shows the head entry, zero when empty);
// count = number of stored entries.
// Push and pop in the same cycle are allowed even when full. The caller
// never pushes into a full FIFO unless it also pops.
module sram_rsp_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Storage is not reset; the count gates what is visible.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_aspect_ctrl.sv
// Aspect-ratio access controller in front of a ROW_W-wide SRAM macro.
// Narrow words (ROW_W>>mode bits) are mapped onto rows: the row address and
// slot come from the narrow address, writes replicate the word across all
// slots under a slot mask, and reads extract the slot right-aligned.
// Ports:
//   cfg_valid/cfg_mode/cfg_ready/cfg_err/mode : mode configuration
//   req_valid/req_ready/req_we/req_addr/req_wdata : fabric request
//   sram_en/we/addr/wmask/wdata, sram_rdata : macro side (registered drive)
//   rsp_valid/rsp_ready/rsp_rdata : in-order read responses
// Credits (in-flight reads + buffered responses) throttle requests so the
// response buffer can never overflow.
module sram_aspect_ctrl
  import sram_cfg_pkg::*;
#(
  parameter  int ROW_W      = 32,
  parameter  int ROW_ADDR_W = 10,
  parameter  int RD_LAT     = 1,
  parameter  int RSP_DEPTH  = 2,
  localparam int SLOT_W     = $clog2(ROW_W),
  localparam int ADDR_W     = ROW_ADDR_W + SLOT_W,
  localparam int MODE_W     = $clog2(SLOT_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [MODE_W-1:0]     cfg_mode,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [MODE_W-1:0]     mode,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [ROW_W-1:0]      req_wdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ROW_ADDR_W-1:0] sram_addr,
  output logic [ROW_W-1:0]      sram_wmask,
  output logic [ROW_W-1:0]      sram_wdata,
  input  logic [ROW_W-1:0]      sram_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ROW_W-1:0]      rsp_rdata
);

  localparam int                CRD_W    = $clog2(RSP_DEPTH + 1);
  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(SLOT_W);
  localparam logic [CRD_W-1:0]  CRD_MAX  = CRD_W'(RSP_DEPTH);

  logic [CRD_W-1:0] credits, fifo_cnt;
  logic             cfg_fire, acc, rd_acc, pop;

  // Config may only land when nothing is in flight. With cfg_valid low an
  // idle controller still reports not-ready when a request is taken now.
  assign cfg_ready = (credits == '0) & (cfg_valid | ~req_valid);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign req_ready = (credits < CRD_MAX) & ~cfg_fire;
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & ~req_we;
  assign pop       = rsp_valid & rsp_ready;

  // ---------------- mode register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= MODE_W'(MODE_X32);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_fire & (cfg_mode > MAX_MODE);
      if (cfg_fire && cfg_mode <= MAX_MODE) mode <= cfg_mode;
    end
  end

  // ---------------- request decode ----------------
  int                  word_w;
  logic [SLOT_W-1:0]   slot;
  logic [ROW_ADDR_W-1:0] row;
  logic [ROW_W-1:0]    wrep, wmask_n;

  always_comb begin
    word_w = ROW_W >> mode;
    row    = ROW_ADDR_W'(req_addr >> mode);
    // Slot is the low 'mode' address bits; empty in full-row mode.
    for (int i = 0; i < SLOT_W; i++) slot[i] = req_addr[i] & (i < int'(mode));
    // Replicate the narrow word into every slot.
    for (int i = 0; i < ROW_W; i++) wrep[i] = req_wdata[i & (word_w - 1)];
    wmask_n = ROW_W'(wmask_f(int'(mode), int'(slot), ROW_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wmask <= '0;
      sram_wdata <= '0;
    end else begin
      sram_en    <= acc;
      sram_we    <= acc & req_we;
      sram_addr  <= acc ? row : '0;
      sram_wmask <= (acc & req_we) ? wmask_n : '0;
      sram_wdata <= (acc & req_we) ? wrep : '0;
    end
  end

  // ---------------- read tag pipe ----------------
  // Stage 0 lines up with sram_en; stage RD_LAT lines up with valid rdata.
  // The mode travels with the tag so a later mode change cannot corrupt it.
  logic [RD_LAT:0]             vld_pipe;
  logic [RD_LAT:0][SLOT_W-1:0] slot_pipe;
  logic [RD_LAT:0][MODE_W-1:0] mode_pipe;
  logic [ROW_W-1:0]            push_data;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_acc};
  end

  always_ff @(posedge clk) begin
    slot_pipe <= {slot_pipe[RD_LAT-1:0], slot};
    mode_pipe <= {mode_pipe[RD_LAT-1:0], mode};
  end

  assign push_data = ROW_W'(extract_f(int'(mode_pipe[RD_LAT]), int'(slot_pipe[RD_LAT]),
                                      row_t'(sram_rdata), ROW_W));

  // ---------------- credits ----------------
  always_ff @(posedge clk) begin
    if (rst) credits <= '0;
    else     credits <= credits + CRD_W'(rd_acc) - CRD_W'(pop);
  end

  sram_rsp_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[RD_LAT]),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (rsp_rdata),
    .count     (fifo_cnt)
  );

  assign rsp_valid = fifo_cnt != '0;

endmodule

// File: tb/tb_sram_aspect_ctrl.sv
// Scoreboard bench for sram_aspect_ctrl (ROW_W=32, RD_LAT=1, RSP_DEPTH=2).
// A behavioural macro answers sram_* accesses; a shadow memory predicts read
// words, which are queued at read issue and compared on each response.
module tb_sram_aspect_ctrl;
  localparam int ROW_W = 32, ROW_ADDR_W = 10, RD_LAT = 1, RSP_DEPTH = 2;
  localparam int ADDR_W = 15, MODE_W = 3;

  logic clk = 1'b0;
  logic rst, cfg_valid, cfg_ready, cfg_err, req_valid, req_ready, req_we;
  logic [MODE_W-1:0] cfg_mode, mode;
  logic [ADDR_W-1:0] req_addr;
  logic [ROW_W-1:0]  req_wdata, sram_wmask, sram_wdata, rsp_rdata;
  logic [ROW_W-1:0]  sram_rdata = '0;
  logic              sram_en, sram_we, rsp_valid, rsp_ready;
  logic [ROW_ADDR_W-1:0] sram_addr;

  always #5 clk = ~clk;

  sram_aspect_ctrl #(.ROW_W(ROW_W), .ROW_ADDR_W(ROW_ADDR_W), .RD_LAT(RD_LAT),
                     .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .mode(mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata));

  // Behavioural macro, one-cycle read latency.
  logic [ROW_W-1:0] macro [0:(1<<ROW_ADDR_W)-1];
  always @(posedge clk)
    if (sram_en) begin
      if (sram_we) macro[sram_addr] <= (macro[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else         sram_rdata <= macro[sram_addr];
    end

  int n_tests = 0, n_fail = 0;
  int cur_mode = 0;
  logic [31:0] shadow [0:1023];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_write(input int k, input int a, input logic [31:0] d);
    int w = 32 >> k;
    int s = a & ((1 << k) - 1);
    int r = (a >> k) & 1023;
    logic [63:0] mm;
    logic [31:0] m, rep;
    mm = ((64'd1 << w) - 1) << (s * w);
    m  = mm[31:0];
    for (int i = 0; i < 32; i++) rep[i] = d[i % w];
    shadow[r] = (shadow[r] & ~m) | (rep & m);
  endfunction

  function automatic logic [31:0] ref_read(input int k, input int a);
    int w = 32 >> k;
    int s = a & ((1 << k) - 1);
    int r = (a >> k) & 1023;
    logic [63:0] t;
    t = ({32'b0, shadow[r]} >> (s * w)) & ((64'd1 << w) - 1);
    return t[31:0];
  endfunction

  // Response monitor: compares each consumed response against the queue.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_rdata, e);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Bounded wait for req_ready; a stall releases rsp_ready so credits return.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
      step();
      rsp_ready = 1'b1;
    end
  endtask

  task automatic issue(input bit we, input int a, input logic [31:0] d);
    bit ok;
    req_valid = 1'b1; req_we = we; req_addr = ADDR_W'(a); req_wdata = d;
    wait_req(ok);
    chk("req_accept", ok, 1);
    if (ok) begin
      if (we) ref_write(cur_mode, a, d);
      else    exp_q.push_back(ref_read(cur_mode, a));
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic set_mode(input int k);
    bit ok;
    cfg_valid = 1'b1; cfg_mode = MODE_W'(k);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1'b1; break; end
      step();
      rsp_ready = 1'b1;
    end
    chk("cfg_accept", ok, 1);
    step();
    cfg_valid = 1'b0;
    cur_mode = k;
    @(negedge clk);
    chk("mode", mode, k);
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    step();
  endtask

  initial begin
    bit ok, bad;
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = '0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_mode", mode, 0);        chk("rst_cfg_err", cfg_err, 0);
    chk("rst_sram_en", sram_en, 0);  chk("rst_sram_wmask", sram_wmask, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
    step();
    rst = 1'b0; rsp_ready = 1'b1;

    // Full-row mode: clear the rows used later.
    foreach (shadow[i]) if (i == 0 || i == 1 || i == 2 || i == 4) issue(1'b1, i, 32'h0);

    // Mode 2 write, exact macro drive one cycle after accept.
    set_mode(2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h006; req_wdata = 32'hA5;
    @(negedge clk); chk("t1_ready", req_ready, 1);
    step(); req_valid = 1'b0; ref_write(2, 6, 32'hA5);
    @(negedge clk);
    chk("t1_en", sram_en, 1); chk("t1_we", sram_we, 1); chk("t1_addr", sram_addr, 1);
    chk("t1_wmask", sram_wmask, 32'h00FF0000); chk("t1_wdata", sram_wdata, 32'hA5A5A5A5);
    step(); @(negedge clk); chk("t1_en_pulse", sram_en, 0);
    step();

    // Mode 5 single-bit read, latency check.
    set_mode(5);
    issue(1'b1, 'h1F, 32'h1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h01F;
    @(negedge clk); chk("t2_ready", req_ready, 1);
    exp_q.push_back(ref_read(5, 'h1F));
    step(); req_valid = 1'b0;
    @(negedge clk); chk("t2_lat_t1", rsp_valid, 0);
    step(); @(negedge clk); chk("t2_lat_t2", rsp_valid, 0);
    step(); @(negedge clk); chk("t2_lat_t3", rsp_valid, 1); chk("t2_data", rsp_rdata, 32'h1);
    step();
    issue(1'b0, 'h1E, 32'h0);
    drain();

    // Credit limit with rsp_ready low; in-order drain.
    set_mode(3);
    issue(1'b1, 'h10, 32'h3); issue(1'b1, 'h11, 32'hC); issue(1'b1, 'h12, 32'h5);
    rsp_ready = 1'b0;
    issue(1'b0, 'h10, 0); issue(1'b0, 'h11, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h012;
    bad = 1'b0;
    for (int n = 0; n < 4; n++) begin @(negedge clk); if (req_ready) bad = 1'b1; end
    chk("t3_stall", bad, 0);
    chk("t3_hold_valid", rsp_valid, 1); chk("t3_hold_data", rsp_rdata, 32'h3);
    step(); rsp_ready = 1'b1;
    wait_req(ok); chk("t3_third", ok, 1);
    if (ok) exp_q.push_back(ref_read(3, 'h12));
    step(); req_valid = 1'b0;
    drain();

    // Config blocked while responses are pending.
    rsp_ready = 1'b0;
    issue(1'b0, 'h10, 0); issue(1'b0, 'h11, 0);
    cfg_valid = 1'b1; cfg_mode = 3'd1;
    bad = 1'b0;
    for (int n = 0; n < 3; n++) begin @(negedge clk); if (cfg_ready) bad = 1'b1; end
    chk("t4_cfg_block", bad, 0); chk("t4_mode_hold", mode, 3);
    step(); rsp_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (cfg_ready) begin ok = 1'b1; break; end end
    chk("t4_cfg_ready", ok, 1);
    step(); cfg_valid = 1'b0; cur_mode = 1;
    @(negedge clk); chk("t4_mode", mode, 1); chk("t4_drained", exp_q.size(), 0);
    step();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h001; req_wdata = 32'h1234;
    @(negedge clk); step(); req_valid = 1'b0; ref_write(1, 1, 32'h1234);
    @(negedge clk);
    chk("t4_wmask", sram_wmask, 32'hFFFF0000); chk("t4_wdata", sram_wdata, 32'h12341234);
    chk("t4_addr", sram_addr, 0);
    step();

    // Illegal mode, then config/request tie.
    cfg_valid = 1'b1; cfg_mode = 3'd6;
    @(negedge clk); chk("t5_cfg_ready", cfg_ready, 1);
    step(); cfg_valid = 1'b0;
    @(negedge clk); chk("t5_err", cfg_err, 1); chk("t5_mode", mode, 1);
    step(); @(negedge clk); chk("t5_err_pulse", cfg_err, 0);
    step();
    cfg_valid = 1'b1; cfg_mode = 3'd2;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h003; req_wdata = 32'hFF;
    @(negedge clk); chk("t5_tie_req", req_ready, 0); chk("t5_tie_cfg", cfg_ready, 1);
    step(); cfg_valid = 1'b0; req_valid = 1'b0; cur_mode = 2;
    @(negedge clk); chk("t5_tie_en", sram_en, 0); chk("t5_tie_mode", mode, 2);
    step();

    // Mode 4 writes then reads with random response back-pressure.
    set_mode(4);
    for (int i = 0; i < 8; i++) issue(1'b1, 'h40 + i, $urandom);
    for (int i = 0; i < 8; i++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      issue(1'b0, 'h40 + i, 0);
    end
    rsp_ready = 1'b1;
    drain();

    // Reset one cycle after a read accept.
    set_mode(2);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h000;
    @(negedge clk); step(); req_valid = 1'b0;
    rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t6_mode", mode, 0); chk("t6_en", sram_en, 0); chk("t6_addr", sram_addr, 0);
    chk("t6_wmask", sram_wmask, 0); chk("t6_wdata", sram_wdata, 0);
    chk("t6_rsp_rdata", rsp_rdata, 0); chk("t6_cfg_ready", cfg_ready, 1);
    bad = 1'b0;
    for (int n = 0; n < 6; n++) begin @(negedge clk); if (rsp_valid) bad = 1'b1; end
    chk("t6_no_rsp", bad, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
